uart_boot_loader: RTL and testbench

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

---
 rtl/uart_boot_loader.sv | 185 ++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// UART receiver feeding a boot loader that writes a checksummed image into instruction memory
// and holds the CPU in reset until the image is verified.
module uart_boot_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned IMEM_WORDS   = 64,
  localparam int unsigned AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          uart_rx,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_hold,
  output logic          boot_done,
  output logic          boot_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HalfCnt = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FullCnt = CW'(CLKS_PER_BIT - 1);

  // rx_prev_q trails the synchronizer by one cycle for falling-edge detection
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  typedef enum logic [1:0] {RxIdle, RxStart, RxBits, RxStop} rx_state_e;

  rx_state_e       rx_state_q;
  logic [CW-1:0]   rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shift_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      unique case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RxStart;
            rx_cnt_q   <= '0;
          end
        end
        RxStart: begin
          if (rx_cnt_q == HalfCnt) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? RxIdle : RxBits;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RxBits: begin
          if (rx_cnt_q == FullCnt) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (rx_cnt_q == FullCnt) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RxIdle;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // Single-cycle strobe at the stop-bit sample; the stop level decides good byte vs framing error
  logic byte_valid, byte_ok, byte_bad;
  assign byte_valid = (rx_state_q == RxStop) && (rx_cnt_q == FullCnt);
  assign byte_ok    = byte_valid && rx_sync_q;
  assign byte_bad   = byte_valid && !rx_sync_q;

  typedef enum logic [2:0] {LdSync, LdCount, LdData, LdCheck, LdDone, LdErr} ld_state_e;

  ld_state_e   ld_state_q;
  logic [7:0]  word_cnt_q;
  logic [1:0]  byte_idx_q;
  logic [23:0] word_q;
  logic [7:0]  csum_q;
  logic        last_word;

  assign last_word = (int'(imem_addr) + 1) == int'(word_cnt_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state_q <= LdSync;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      boot_done  <= 1'b0;
      boot_err   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      unique case (ld_state_q)
        LdSync: begin
          if (byte_ok && rx_shift_q == 8'hA5) begin
            ld_state_q <= LdCount;
            csum_q     <= '0;
            imem_addr  <= '0;
            byte_idx_q <= '0;
          end
        end
        LdCount: begin
          if (byte_bad || (byte_ok && (rx_shift_q == 8'd0 || {24'd0, rx_shift_q} > IMEM_WORDS)))
          begin
            ld_state_q <= LdErr;
            boot_err   <= 1'b1;
          end else if (byte_ok) begin
            word_cnt_q <= rx_shift_q;
            ld_state_q <= LdData;
          end
        end
        LdData: begin
          // Address advances the cycle after each write; leave only once the last word is out
          if (imem_we) begin
            imem_addr <= imem_addr + 1'b1;
            if (last_word) ld_state_q <= LdCheck;
          end else if (byte_bad) begin
            ld_state_q <= LdErr;
            boot_err   <= 1'b1;
          end else if (byte_ok) begin
            csum_q     <= csum_q ^ rx_shift_q;
            word_q     <= {word_q[15:0], rx_shift_q};
            byte_idx_q <= byte_idx_q + 1'b1;
            if (byte_idx_q == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {word_q, rx_shift_q};
            end
          end
        end
        LdCheck: begin
          if (byte_ok && rx_shift_q == csum_q) begin
            ld_state_q <= LdDone;
            boot_done  <= 1'b1;
            cpu_hold   <= 1'b0;
          end else if (byte_valid) begin
            ld_state_q <= LdErr;
            boot_err   <= 1'b1;
          end
        end
        LdDone: ;
        LdErr: begin
          if (byte_ok && rx_shift_q == 8'hA5) begin
            ld_state_q <= LdCount;
            boot_err   <= 1'b0;
            imem_addr  <= '0;
            csum_q     <= '0;
            byte_idx_q <= '0;
          end
        end
        default: ld_state_q <= LdSync;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: vector table, hand-written corner cases and random
// images checked against a stream-parsing reference model.
module tb_uart_boot_loader;

  localparam int unsigned CPB   = 4;
  localparam int          WORDS = 64;
  localparam logic [7:0]  GOOD_IMG [11] = '{8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                                            8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        boot_done;
  logic        boot_err;

  uart_boot_loader #(
    .CLKS_PER_BIT(CPB),
    .IMEM_WORDS  (WORDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .boot_done (boot_done),
    .boot_err  (boot_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(int'(imem_addr));
      wr_data_q.push_back(imem_wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"}, imem_we, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_wdata"}, imem_wdata, 0);
    check({tag, "_hold"}, cpu_hold, 1);
    check({tag, "_done"}, boot_done, 0);
    check({tag, "_err"}, boot_err, 0);
  endtask

  task automatic check_write(input string tag, input int k, input int ea, input logic [31:0] ed);
    if (k < wr_addr_q.size()) begin
      check({tag, "_addr"}, wr_addr_q[k], ea);
      check({tag, "_data"}, wr_data_q[k], ed);
    end else begin
      check({tag, "_missing"}, wr_addr_q.size(), k + 1);
    end
  endtask

  // Starts and ends on a falling clock edge
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_good(input int from, input int to);
    for (int i = from; i < to; i++) send_byte(GOOD_IMG[i], 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_wr();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Reference model: parse the byte stream as sync / count / big-endian words / checksum
  logic [7:0]  stream_q[$];
  int          exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  bit          exp_done, exp_err;

  task automatic model_image();
    int i;
    int n;
    logic [7:0]  cs;
    logic [31:0] w;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    i = 0;
    while (i < stream_q.size() && stream_q[i] != 8'hA5) i++;
    i++;
    if (i >= stream_q.size()) return;
    n = int'(stream_q[i]);
    i++;
    if (n == 0 || n > WORDS) begin
      exp_err = 1'b1;
      return;
    end
    cs = 8'h00;
    for (int k = 0; k < n; k++) begin
      if (i + 4 > stream_q.size()) return;
      w  = {stream_q[i], stream_q[i+1], stream_q[i+2], stream_q[i+3]};
      cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      exp_addr_q.push_back(k);
      exp_data_q.push_back(w);
      i += 4;
    end
    if (i >= stream_q.size()) return;
    if (stream_q[i] == cs) exp_done = 1'b1;
    else exp_err = 1'b1;
  endtask

  typedef struct packed {
    logic [95:0] seq;
    int          n;
    int          bad;
    bit          pre_rst;
    bit          exp_done;
    bit          exp_err;
    int          exp_nwr;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{seq: 96'hA5_02_20_08_00_05_20_09_00_0A_0E_00, n: 11, bad: -1, pre_rst: 1'b1,
                exp_done: 1'b1, exp_err: 1'b0, exp_nwr: 2, w0: 32'h20080005, w1: 32'h2009000A};
    vecs[1] = '{seq: 96'hA5_02_20_08_00_05_20_09_00_0A_0F_00, n: 11, bad: -1, pre_rst: 1'b1,
                exp_done: 1'b0, exp_err: 1'b1, exp_nwr: 2, w0: 32'h20080005, w1: 32'h2009000A};
    vecs[2] = '{seq: 96'hA5_02_20_08_00_05_20_09_00_0A_0E_00, n: 11, bad: -1, pre_rst: 1'b0,
                exp_done: 1'b1, exp_err: 1'b0, exp_nwr: 2, w0: 32'h20080005, w1: 32'h2009000A};
    vecs[3] = '{seq: 96'hA5_00_00_00_00_00_00_00_00_00_00_00, n: 2, bad: -1, pre_rst: 1'b1,
                exp_done: 1'b0, exp_err: 1'b1, exp_nwr: 0, w0: 32'h0, w1: 32'h0};
    vecs[4] = '{seq: 96'hA5_41_00_00_00_00_00_00_00_00_00_00, n: 2, bad: -1, pre_rst: 1'b0,
                exp_done: 1'b0, exp_err: 1'b1, exp_nwr: 0, w0: 32'h0, w1: 32'h0};
    vecs[5] = '{seq: 96'hA5_02_20_08_00_00_00_00_00_00_00_00, n: 5, bad: 4, pre_rst: 1'b1,
                exp_done: 1'b0, exp_err: 1'b1, exp_nwr: 0, w0: 32'h0, w1: 32'h0};
    vecs[6] = '{seq: 96'h00_FF_5A_A5_01_DE_AD_BE_EF_22_00_00, n: 10, bad: -1, pre_rst: 1'b1,
                exp_done: 1'b1, exp_err: 1'b0, exp_nwr: 1, w0: 32'hDEADBEEF, w1: 32'h0};
    vecs[7] = '{seq: 96'hA5_01_11_22_33_44_44_00_00_00_00_00, n: 7, bad: -1, pre_rst: 1'b0,
                exp_done: 1'b1, exp_err: 1'b0, exp_nwr: 0, w0: 32'h0, w1: 32'h0};

    // Reset values, then a long idle stretch must change nothing
    rst     = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check_reset_vals("idle");
    check("idle_nwr", wr_addr_q.size(), 0);

    for (int v = 0; v < 8; v++) begin
      vec_t        cur;
      logic [95:0] seq;
      cur = vecs[v];
      if (cur.pre_rst) do_reset();
      clear_wr();
      seq = cur.seq;
      for (int j = 0; j < cur.n; j++) send_byte(seq[95-8*j -: 8], j != cur.bad);
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_done", v), boot_done, cur.exp_done);
      check($sformatf("v%0d_err", v), boot_err, cur.exp_err);
      check($sformatf("v%0d_hold", v), cpu_hold, !cur.exp_done);
      check($sformatf("v%0d_nwr", v), wr_addr_q.size(), cur.exp_nwr);
      if (cur.exp_nwr >= 1) check_write($sformatf("v%0d_w0", v), 0, 0, cur.w0);
      if (cur.exp_nwr >= 2) check_write($sformatf("v%0d_w1", v), 1, 1, cur.w1);
    end

    // boot_done must rise around the end of the checksum stop bit, not earlier
    do_reset();
    clear_wr();
    send_good(0, 10);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = GOOD_IMG[10][i];
      repeat (CPB) @(negedge clk);
    end
    check("tim_early_done", boot_done, 0);
    check("tim_early_hold", cpu_hold, 1);
    uart_rx = 1'b1;
    repeat (CPB + 2) @(negedge clk);
    check("tim_done", boot_done, 1);
    check("tim_hold", cpu_hold, 0);
    repeat (2 * CPB) @(negedge clk);

    // One-cycle low glitches on the idle line, in SYNC and in the middle of a word
    do_reset();
    clear_wr();
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    send_good(0, 4);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    check("gl_nwr_mid", wr_addr_q.size(), 0);
    check("gl_err_mid", boot_err, 0);
    send_good(4, 11);
    check("gl_done", boot_done, 1);
    check_write("gl_w0", 0, 0, 32'h20080005);
    check_write("gl_w1", 1, 1, 32'h2009000A);

    // Asynchronous reset in the middle of the second word, then a clean reload
    do_reset();
    clear_wr();
    send_good(0, 8);
    check("mr_nwr_pre", wr_addr_q.size(), 1);
    uart_rx = 1'b0;
    repeat (6) @(negedge clk);
    #3 rst = 1'b1;
    #1 check_reset_vals("mr_async");
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    clear_wr();
    send_good(0, 11);
    check("mr_done", boot_done, 1);
    check("mr_err", boot_err, 0);
    check("mr_nwr", wr_addr_q.size(), 2);
    check_write("mr_w0", 0, 0, 32'h20080005);
    check_write("mr_w1", 1, 1, 32'h2009000A);

    // Random images against the reference model
    for (int it = 0; it < 10; it++) begin
      int          nj, mode, n;
      logic [7:0]  b, cs;
      do_reset();
      clear_wr();
      stream_q.delete();
      nj = int'($urandom_range(0, 2));
      for (int k = 0; k < nj; k++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        stream_q.push_back(b);
      end
      stream_q.push_back(8'hA5);
      mode = int'($urandom_range(0, 7));
      if (mode == 0) begin
        if ($urandom_range(0, 1) == 0) n = 0;
        else n = int'($urandom_range(65, 255));
        stream_q.push_back(8'(n));
      end else begin
        n = int'($urandom_range(1, 4));
        stream_q.push_back(8'(n));
        cs = 8'h00;
        for (int k = 0; k < 4 * n; k++) begin
          b  = 8'($urandom);
          cs = cs ^ b;
          stream_q.push_back(b);
        end
        if (mode == 1) cs = cs ^ 8'($urandom_range(1, 255));
        stream_q.push_back(cs);
      end
      model_image();
      foreach (stream_q[k]) send_byte(stream_q[k], 1'b1);
      repeat (2) @(negedge clk);
      check($sformatf("rnd%0d_done", it), boot_done, exp_done);
      check($sformatf("rnd%0d_err", it), boot_err, exp_err);
      check($sformatf("rnd%0d_hold", it), cpu_hold, !exp_done);
      check($sformatf("rnd%0d_nwr", it), wr_addr_q.size(), exp_addr_q.size());
      foreach (exp_addr_q[k])
        check_write($sformatf("rnd%0d_w%0d", it, k), k, exp_addr_q[k], exp_data_q[k]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
